// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Fetches always read a full word.
    localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/arb_timer.sv
// Transaction timeout counter for the memory port arbiter.
// Ports: clk, reset (async, active-high), clr (zero the count; wins over en),
//        en (count one stalled busy cycle), expire (this stalled cycle is the last allowed).
module arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;
    logic [7:0] count_next;

    always_comb begin
        count_next = count;
        if (clr)     count_next = '0;
        else if (en) count_next = count + 8'd1;
    end

    flopr #(.WIDTH(8)) u_count (
        .clk   (clk),
        .reset (reset),
        .d     (count_next),
        .q     (count)
    );

    assign expire = en & (count == LAST);

endmodule

// File: rtl/flopenr.sv
// Resettable register cell with load enable.
// Ports: clk, reset (async, active-high), en (load d), d, q (0 on reset).
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/flopr.sv
// Resettable register cell.
// Ports: clk, reset (async, active-high), d (next value), q (stored value, 0 on reset).
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port (read-only) and the data port
// (load/store). Data wins contention, except that fetch is forced through after
// MAX_DSTREAK consecutive data grants made while fetch waits. A transaction that sees
// no mem_ready for TIMEOUT cycles is aborted with a one-cycle bus_err pulse.
// Ports: clk, reset (async, active-high);
//        fetch side  ireq, iaddr -> irdata, iready, stallF;
//        data side   dreq, dwe, daddr, dwdata, dbe -> drdata, dready, stallM;
//        memory side mem_req, mem_we, mem_addr, mem_wdata, mem_be <- mem_rdata, mem_ready;
//        bus_err: pulse after a timeout abort.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic [31:0] irdata,
    output logic        iready,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dbe,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stallF,
    output logic        stallM,
    output logic        bus_err
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    logic [1:0] state_bits;
    arb_state_t state;
    arb_state_t state_next;
    logic [3:0] dstreak;
    logic [3:0] dstreak_next;
    logic       busy_i, busy_d, busy;
    logic       arb_ok, i_pend, d_pend, streak_full;
    logic       grant_i, grant_d, grant;
    logic       expire;

    assign state  = arb_state_t'(state_bits);
    assign busy_i = (state == BUSY_I);
    assign busy_d = (state == BUSY_D);
    assign busy   = busy_i | busy_d;

    // Arbitrate when idle or in the completing cycle; the completing port's own
    // request is excluded so the other side gets the back-to-back slot.
    assign arb_ok      = ~busy | mem_ready;
    assign i_pend      = ireq & ~busy_i;
    assign d_pend      = dreq & ~busy_d;
    assign streak_full = (dstreak == STREAK_MAX);
    assign grant_i     = arb_ok & i_pend & (~d_pend | streak_full);
    assign grant_d     = arb_ok & d_pend & ~grant_i;
    assign grant       = grant_i | grant_d;

    always_comb begin
        state_next = state;
        if (grant_i)               state_next = BUSY_I;
        else if (grant_d)          state_next = BUSY_D;
        else if (arb_ok | expire)  state_next = IDLE;
    end

    always_comb begin
        dstreak_next = dstreak;
        if (~ireq | grant_i)              dstreak_next = '0;
        else if (grant_d & ~streak_full)  dstreak_next = dstreak + 4'd1;
    end

    flopr #(.WIDTH(2)) u_state (
        .clk   (clk),
        .reset (reset),
        .d     (state_next),
        .q     (state_bits)
    );

    flopr #(.WIDTH(4)) u_dstreak (
        .clk   (clk),
        .reset (reset),
        .d     (dstreak_next),
        .q     (dstreak)
    );

    flopr #(.WIDTH(1)) u_bus_err (
        .clk   (clk),
        .reset (reset),
        .d     (expire),
        .q     (bus_err)
    );

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (grant),
        .en     (busy & ~mem_ready),
        .expire (expire)
    );

    flopenr #(.WIDTH(32)) u_mem_addr (
        .clk   (clk),
        .reset (reset),
        .en    (grant),
        .d     (grant_i ? iaddr : daddr),
        .q     (mem_addr)
    );

    flopenr #(.WIDTH(32)) u_mem_wdata (
        .clk   (clk),
        .reset (reset),
        .en    (grant),
        .d     (dwdata),
        .q     (mem_wdata)
    );

    flopenr #(.WIDTH(4)) u_mem_be (
        .clk   (clk),
        .reset (reset),
        .en    (grant),
        .d     (grant_i ? FETCH_BE : dbe),
        .q     (mem_be)
    );

    flopenr #(.WIDTH(1)) u_mem_we (
        .clk   (clk),
        .reset (reset),
        .en    (grant),
        .d     (grant_d & dwe),
        .q     (mem_we)
    );

    assign mem_req = busy;
    assign iready  = busy_i & mem_ready;
    assign dready  = busy_d & mem_ready;
    assign irdata  = mem_rdata;
    assign drdata  = mem_rdata;
    assign stallF  = ireq & ~iready;
    assign stallM  = dreq & ~dready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic        clk = 0, reset = 1;
    logic        ireq = 0, dreq = 0, dwe = 0, mem_ready = 0;
    logic [31:0] iaddr = 0, daddr = 0, dwdata = 0, mem_rdata = 0;
    logic [3:0]  dbe = 0;
    logic [31:0] irdata, drdata, mem_addr, mem_wdata;
    logic        iready, dready, mem_req, mem_we, stallF, stallM, bus_err;
    logic [3:0]  mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.MAX_DSTREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
        .drdata(drdata), .dready(dready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stallF(stallF), .stallM(stallM), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1;
        #3;
        n_cmp++;
        if ({mem_req, mem_we, iready, dready, bus_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b wanted 00000",
                     {mem_req, mem_we, iready, dready, bus_err});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
            n_bad++;
            $display("FAIL reset_regs: got %h %h %h wanted zeros", mem_addr, mem_wdata, mem_be);
        end
        @(negedge clk);
        reset = 0;
        next_cycle();
    endtask

    task automatic test_fetch_only();
        ireq = 1; iaddr = 32'h100; mem_ready = 0;
        #1;
        n_cmp++;
        if ({stallF, mem_req} !== 2'b10) begin
            n_bad++; $display("FAIL fetch_c0: got stallF,mem_req=%b wanted 10", {stallF, mem_req});
        end
        next_cycle();
        n_cmp++;
        if ({mem_req, mem_we, iready, stallF} !== 4'b1001 || mem_addr !== 32'h100 ||
            mem_be !== 4'hf) begin
            n_bad++;
            $display("FAIL fetch_c1: got req/we/rdy/stall=%b addr=%h be=%h wanted 1001 100 f",
                     {mem_req, mem_we, iready, stallF}, mem_addr, mem_be);
        end
        next_cycle();
        mem_ready = 1; mem_rdata = 32'hE3A00001;
        #1;
        n_cmp++;
        if ({mem_req, iready, stallF} !== 3'b110 || irdata !== 32'hE3A00001) begin
            n_bad++;
            $display("FAIL fetch_c2: got req/rdy/stall=%b rdata=%h wanted 110 e3a00001",
                     {mem_req, iready, stallF}, irdata);
        end
        next_cycle();
        ireq = 0; mem_ready = 0;
        #1;
        n_cmp++;
        if ({mem_req, iready} !== 2'b00) begin
            n_bad++; $display("FAIL fetch_c3: got req,rdy=%b wanted 00", {mem_req, iready});
        end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        ireq = 1; iaddr = 32'h300;
        dreq = 1; dwe = 1; daddr = 32'h200; dwdata = 32'hCAFEF00D; dbe = 4'b0011;
        next_cycle();
        mem_ready = 1;
        #1;
        n_cmp++;
        if ({mem_req, mem_we, dready, iready, stallF} !== 5'b11101 || mem_be !== 4'b0011 ||
            mem_addr !== 32'h200 || mem_wdata !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL simul_d: got flags=%b be=%b addr=%h wd=%h wanted 11101 0011 200 cafef00d",
                     {mem_req, mem_we, dready, iready, stallF}, mem_be, mem_addr, mem_wdata);
        end
        next_cycle();
        dreq = 0;
        #1;
        n_cmp++;
        if ({mem_req, mem_we, iready} !== 3'b101 || mem_addr !== 32'h300 || mem_be !== 4'hf) begin
            n_bad++;
            $display("FAIL simul_i: got req/we/rdy=%b addr=%h be=%h wanted 101 300 f",
                     {mem_req, mem_we, iready}, mem_addr, mem_be);
        end
        next_cycle();
        ireq = 0; mem_ready = 0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++; $display("FAIL simul_idle: got mem_req=%b wanted 0", mem_req);
        end
        next_cycle();
    endtask

    task automatic test_timeout(input bit edge_case);
        int bad = 0;
        dreq = 1; dwe = 0; daddr = 32'h400; dbe = 4'hf; mem_ready = 0;
        #1;
        n_cmp++;
        if (stallM !== 1'b1) begin
            n_bad++; $display("FAIL tmo_stall: got stallM=%b wanted 1", stallM);
        end
        next_cycle();
        for (int k = 1; k <= TMO; k++) begin
            if (edge_case && k == TMO) break;
            if ({mem_req, bus_err, dready} !== 3'b100) bad++;
            next_cycle();
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL tmo_busy: got %0d bad busy cycles wanted 0", bad);
        end
        if (edge_case) begin
            mem_ready = 1;
            #1;
            n_cmp++;
            if ({dready, bus_err} !== 2'b10) begin
                n_bad++; $display("FAIL tmo_edge: got dready,bus_err=%b wanted 10", {dready, bus_err});
            end
            dreq = 0;
            next_cycle();
            mem_ready = 0;
            #1;
            n_cmp++;
            if ({mem_req, bus_err} !== 2'b00) begin
                n_bad++; $display("FAIL tmo_edge_after: got req,err=%b wanted 00", {mem_req, bus_err});
            end
        end else begin
            n_cmp++;
            if ({mem_req, bus_err, dready} !== 3'b010) begin
                n_bad++;
                $display("FAIL tmo_abort: got req/err/rdy=%b wanted 010", {mem_req, bus_err, dready});
            end
            next_cycle();
            mem_ready = 1;
            #1;
            n_cmp++;
            if ({mem_req, bus_err, dready} !== 3'b101 || mem_addr !== 32'h400) begin
                n_bad++;
                $display("FAIL tmo_regrant: got req/err/rdy=%b addr=%h wanted 101 400",
                         {mem_req, bus_err, dready}, mem_addr);
            end
            dreq = 0;
            next_cycle();
            mem_ready = 0;
        end
        next_cycle();
    endtask

    // Data keeps timing out while fetch waits: data wins MAXS times, then fetch is forced in.
    task automatic test_starvation();
        ireq = 1; iaddr = 32'h500;
        dreq = 1; dwe = 0; daddr = 32'h600; dbe = 4'hf; mem_ready = 0;
        for (int g = 0; g <= MAXS; g++) begin
            int w = 0;
            while (mem_req !== 1'b1 && w < 200) begin next_cycle(); w++; end
            n_cmp++;
            if (mem_req !== 1'b1) begin
                n_bad++; $display("FAIL starve_wait%0d: got no grant wanted grant", g);
            end
            n_cmp++;
            if (mem_addr !== ((g < MAXS) ? 32'h600 : 32'h500)) begin
                n_bad++;
                $display("FAIL starve_grant%0d: got addr=%h wanted %h", g, mem_addr,
                         (g < MAXS) ? 32'h600 : 32'h500);
            end
            if (g < MAXS) begin
                w = 0;
                while (mem_req !== 1'b0 && w < 200) begin next_cycle(); w++; end
            end
        end
        mem_ready = 1;
        #1;
        n_cmp++;
        if (iready !== 1'b1) begin
            n_bad++; $display("FAIL starve_iready: got %b wanted 1", iready);
        end
        ireq = 0;
        next_cycle();
        n_cmp++;
        if ({mem_req, dready} !== 2'b11 || mem_addr !== 32'h600) begin
            n_bad++;
            $display("FAIL starve_d_after: got req,rdy=%b addr=%h wanted 11 600",
                     {mem_req, dready}, mem_addr);
        end
        dreq = 0;
        next_cycle();
        mem_ready = 0;
        next_cycle();
    endtask

    task automatic test_reset_mid_op();
        int bad = 0;
        dreq = 1; dwe = 1; daddr = 32'h700; dwdata = 32'h1234; dbe = 4'hc; mem_ready = 0;
        next_cycle();
        n_cmp++;
        if ({mem_req, mem_we} !== 2'b11) begin
            n_bad++; $display("FAIL rst_mid_busy: got req,we=%b wanted 11", {mem_req, mem_we});
        end
        reset = 1; mem_ready = 1;
        #1;
        n_cmp++;
        if ({mem_req, mem_we, dready, iready, bus_err} !== 5'b0 ||
            {mem_addr, mem_wdata, mem_be} !== 68'h0) begin
            n_bad++;
            $display("FAIL rst_mid_async: got flags=%b addr=%h be=%h wanted 00000 0 0",
                     {mem_req, mem_we, dready, iready, bus_err}, mem_addr, mem_be);
        end
        dreq = 0;
        next_cycle();
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            if ({mem_req, dready} !== 2'b00) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL rst_mid_release: got %0d cycles with req/dready wanted 0", bad);
        end
        mem_ready = 0;
    endtask

    task automatic test_random(input int ncyc);
        int          owner = 0, waited = 0, streak = 0, stall = 0, pick;
        bit          err = 0, i_hold = 0, d_hold = 0, exp_i, exp_d, can_pick, want_i, want_d;
        logic [31:0] m_addr = 0, m_wdata = 0;
        logic [3:0]  m_be = 0;
        bit          m_we = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (!i_hold) begin
                ireq = ($urandom_range(0, 2) != 0);
                iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_hold) begin
                dreq = ($urandom_range(0, 2) != 0);
                dwe = 1'($urandom_range(0, 1));
                daddr = $urandom;
                dwdata = $urandom;
                dbe = 4'($urandom_range(1, 15));
            end
            if (stall == 0 && $urandom_range(0, 199) == 0) stall = 70;
            if (stall > 0) begin mem_ready = 0; stall--; end
            else mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = $urandom;
            #1;
            exp_i = (owner == 1) && mem_ready;
            exp_d = (owner == 2) && mem_ready;
            n_cmp++;
            if ({mem_req, iready, dready, bus_err} !== {owner != 0, exp_i, exp_d, err}) begin
                n_bad++;
                $display("FAIL rnd_ctrl c%0d: got req/irdy/drdy/err=%b wanted %b", c,
                         {mem_req, iready, dready, bus_err}, {owner != 0, exp_i, exp_d, err});
            end
            n_cmp++;
            if ({stallF, stallM} !== {ireq && !exp_i, dreq && !exp_d}) begin
                n_bad++;
                $display("FAIL rnd_stall c%0d: got %b wanted %b", c, {stallF, stallM},
                         {ireq && !exp_i, dreq && !exp_d});
            end
            n_cmp++;
            if (mem_addr !== m_addr || mem_be !== m_be || mem_we !== m_we ||
                (m_we && mem_wdata !== m_wdata)) begin
                n_bad++;
                $display("FAIL rnd_mem c%0d: got %h/%h/%b/%h wanted %h/%h/%b/%h", c,
                         mem_addr, mem_be, mem_we, mem_wdata, m_addr, m_be, m_we, m_wdata);
            end
            n_cmp++;
            if ((exp_i && irdata !== mem_rdata) || (exp_d && drdata !== mem_rdata)) begin
                n_bad++;
                $display("FAIL rnd_rdata c%0d: got i=%h d=%h wanted %h", c, irdata, drdata,
                         mem_rdata);
            end
            // Reference update for the coming edge.
            can_pick = (owner == 0) || mem_ready;
            want_i = ireq && owner != 1;
            want_d = dreq && owner != 2;
            pick = 0;
            if (can_pick) begin
                if (want_i && want_d) pick = (streak == MAXS) ? 1 : 2;
                else if (want_i) pick = 1;
                else if (want_d) pick = 2;
            end
            err = (owner != 0) && !mem_ready && (waited + 1 == TMO);
            if (!ireq || pick == 1) streak = 0;
            else if (pick == 2 && streak < MAXS) streak++;
            if (pick != 0) begin
                waited = 0;
                m_addr = (pick == 1) ? iaddr : daddr;
                m_be = (pick == 1) ? 4'hf : dbe;
                m_we = (pick == 2) && dwe;
                m_wdata = dwdata;
            end else if (owner != 0 && !mem_ready) begin
                waited++;
            end
            if (can_pick) owner = pick;
            else if (err) owner = 0;
            i_hold = ireq && !exp_i;
            d_hold = dreq && !exp_d;
            next_cycle();
        end
        ireq = 0; dreq = 0; mem_ready = 0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_starvation();
        test_reset_mid_op();
        test_random(1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
